// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - fetch-side RAS push/pop sequencer with registered next-PC prediction; optional coroutine swap under RAS_COROUTINE_EN
module ras_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [1:0]               out_kind,
    output logic                     out_taken,
    output logic [31:0]              out_target,
    output logic [31:0]              ras_waddr,
    output logic                     ras_w_en,
    output logic                     ras_r_en,
    input  logic [31:0]              ras_raddr,
    output logic [$clog2(DEPTH):0]   ras_occ
);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_JUMP = 2'b01;
    localparam logic [1:0] KIND_CALL = 2'b10;
    localparam logic [1:0] KIND_RET  = 2'b11;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic          is_jal;
    logic          is_jalr;
    logic          rd_link;
    logic          rs1_link;
    logic [31:0]   j_imm;
    logic [31:0]   pc_plus4;
    logic [OW-1:0] occ;
    logic          occ_nz;
    logic          accept;
    logic          in_swap;
    logic [31:0]   push_addr;

    logic [1:0]    dec_kind;
    logic          dec_taken;
    logic [31:0]   dec_target;
    logic          dec_push;
    logic          dec_pop;

`ifdef RAS_COROUTINE_EN
    typedef enum logic {
        S_IDLE      = 1'b0,
        S_SWAP_PUSH = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          dec_coro;
    logic [31:0]   swap_addr;
`endif

    assign rd       = in_instr[11:7];
    assign rs1      = in_instr[19:15];
    assign is_jal   = (in_instr[6:0] == OP_JAL);
    assign is_jalr  = (in_instr[6:0] == OP_JALR) && (in_instr[14:12] == 3'b000);
    assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign j_imm    = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign pc_plus4 = in_pc + 32'd4;
    assign occ_nz   = (occ != '0);
    assign ras_occ  = occ;

    // Classify the fetched word and decide what the RAS must do for it.
    // Untaken predictions carry a zero target so consumers never see stale addresses.
    always_comb begin
        dec_kind   = KIND_NONE;
        dec_taken  = 1'b0;
        dec_target = 32'd0;
        dec_push   = 1'b0;
        dec_pop    = 1'b0;
`ifdef RAS_COROUTINE_EN
        dec_coro   = 1'b0;
`endif
        if (is_jal) begin
            dec_kind   = rd_link ? KIND_CALL : KIND_JUMP;
            dec_taken  = 1'b1;
            dec_target = in_pc + j_imm;
            dec_push   = rd_link;
        end else if (is_jalr) begin
            if (rd_link && rs1_link && (rd != rs1)) begin
`ifdef RAS_COROUTINE_EN
                // Swap: pop now, push the link one cycle later from SWAP_PUSH.
                dec_kind   = KIND_RET;
                dec_coro   = 1'b1;
                dec_pop    = occ_nz;
                dec_taken  = occ_nz;
                dec_target = occ_nz ? ras_raddr : 32'd0;
`else
                dec_kind   = KIND_CALL;
                dec_push   = 1'b1;
`endif
            end else if (rd_link) begin
                dec_kind = KIND_CALL;
                dec_push = 1'b1;
            end else if (rs1_link) begin
                // Never pop an empty shadow stack; the prediction just goes untaken.
                dec_kind   = KIND_RET;
                dec_pop    = occ_nz;
                dec_taken  = occ_nz;
                dec_target = occ_nz ? ras_raddr : 32'd0;
            end
        end
    end

    assign in_ready = reset && !flush && !in_swap && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef RAS_COROUTINE_EN
    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: SWAP_PUSH lasts exactly one cycle, flushed or not.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (accept && dec_coro) state_nxt = S_SWAP_PUSH;
            S_SWAP_PUSH: state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Hold the coroutine's link address for the deferred push.
    always_ff @(posedge clock) begin
        if (!reset) begin
            swap_addr <= 32'd0;
        end else if (accept) begin
            swap_addr <= pc_plus4;
        end
    end

    assign in_swap   = (state == S_SWAP_PUSH);
    assign push_addr = in_swap ? swap_addr : pc_plus4;
`else
    assign in_swap   = 1'b0;
    assign push_addr = pc_plus4;
`endif

    // RAS enables: accept-cycle push/pop, or the deferred swap push; flush or reset kill both.
    always_comb begin
        ras_w_en  = 1'b0;
        ras_r_en  = 1'b0;
        ras_waddr = push_addr;
        if (reset && !flush) begin
            if (in_swap) begin
                ras_w_en = 1'b1;
            end else if (accept) begin
                ras_w_en = dec_push;
                ras_r_en = dec_pop;
            end
        end
    end

    // Shadow occupancy: saturate on push, never underflow on pop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            occ <= '0;
        end else if (ras_w_en) begin
            if (occ != OCC_MAX) begin
                occ <= occ + 1'b1;
            end
        end else if (ras_r_en && occ_nz) begin
            occ <= occ - 1'b1;
        end
    end

    // Prediction register: load on accept, hold under backpressure, drop on flush.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_pc     <= 32'd0;
            out_kind   <= KIND_NONE;
            out_taken  <= 1'b0;
            out_target <= 32'd0;
        end else if (flush) begin
            out_valid  <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_pc     <= in_pc;
            out_kind   <= dec_kind;
            out_taken  <= dec_taken;
            out_target <= dec_target;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - randomized and directed check of ras_ctrl against a queue-based prediction model
module tb_ras_ctrl;
    localparam int DEPTH = 8;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [1:0]  out_kind;
    logic        out_taken;
    logic [31:0] out_target;
    logic [31:0] ras_waddr;
    logic        ras_w_en;
    logic        ras_r_en;
    logic [31:0] ras_raddr;
    logic [3:0]  ras_occ;

    int checks = 0;
    int errors = 0;

    ras_ctrl #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_kind(out_kind),
        .out_taken(out_taken), .out_target(out_target),
        .ras_waddr(ras_waddr), .ras_w_en(ras_w_en), .ras_r_en(ras_r_en),
        .ras_raddr(ras_raddr), .ras_occ(ras_occ)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Attached RAS: circular buffer that wraps, top-of-stack read combinationally.
    logic [31:0] ras_mem [DEPTH];
    logic [2:0]  ras_wp = 3'd0;
    initial for (int i = 0; i < DEPTH; i++) ras_mem[i] = 32'd0;
    assign ras_raddr = ras_mem[ras_wp - 3'd1];
    always @(posedge clock) begin
        if (ras_w_en) begin
            ras_mem[ras_wp] <= ras_waddr;
            ras_wp <= ras_wp + 3'd1;
        end else if (ras_r_en) begin
            ras_wp <= ras_wp - 3'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h000, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    // Prediction rules from the instruction word, stack emptiness and stack top.
    function automatic void classify(input logic [31:0] ins, input logic [31:0] pc,
                                     input bit nonempty, input logic [31:0] top,
                                     output logic [1:0] k, output logic tk,
                                     output logic [31:0] tg, output bit psh,
                                     output bit pp, output bit coro);
        int rd, rs1, imm21, imm;
        bit rdl, rsl, jal, jalr;
        rd    = int'(ins[11:7]);
        rs1   = int'(ins[19:15]);
        rdl   = (rd == 1) || (rd == 5);
        rsl   = (rs1 == 1) || (rs1 == 5);
        jal   = (ins[6:0] == 7'h6F);
        jalr  = (ins[6:0] == 7'h67) && (ins[14:12] == 3'd0);
        imm21 = int'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        imm   = (imm21 >= (1 << 20)) ? imm21 - (1 << 21) : imm21;
        k = 2'd0; tk = 1'b0; tg = 32'd0; psh = 0; pp = 0; coro = 0;
        if (jal) begin
            k = rdl ? 2'd2 : 2'd1;
            tk = 1'b1;
            tg = pc + 32'(imm);
            psh = rdl;
        end else if (jalr) begin
            if (rdl && rsl && rd != rs1) begin
`ifdef RAS_COROUTINE_EN
                k = 2'd3; coro = 1; pp = nonempty; tk = nonempty;
                tg = nonempty ? top : 32'd0;
`else
                k = 2'd2; psh = 1;
`endif
            end else if (rdl) begin
                k = 2'd2; psh = 1;
            end else if (rsl) begin
                k = 2'd3; pp = nonempty; tk = nonempty;
                tg = nonempty ? top : 32'd0;
            end
        end
    endfunction

    // Model state: saturating stack of return addresses and the expected output register.
    logic [31:0] q[$];
    bit          m_pend = 0;
    logic [31:0] m_pend_addr = 32'd0;
    bit          m_ov = 0;
    logic [31:0] m_pc = 32'd0;
    logic [1:0]  m_kind = 2'd0;
    logic        m_taken = 1'b0;
    logic [31:0] m_target = 32'd0;

    function automatic void q_push(input logic [31:0] a);
        q.push_back(a);
        if (q.size() > DEPTH) void'(q.pop_front());
    endfunction

    // Compare every cycle at the falling edge, then advance the model by one cycle.
    always @(negedge clock) begin
        logic [1:0]  k;
        logic        tk;
        logic [31:0] tg, top;
        bit          psh, pp, coro, exp_rdy, acc, exp_w, exp_r;
        top = (q.size() != 0) ? q[q.size()-1] : 32'd0;
        classify(in_instr, in_pc, q.size() != 0, top, k, tk, tg, psh, pp, coro);
        exp_rdy = reset && !flush && !m_pend && (!m_ov || out_ready);
        acc     = in_valid && exp_rdy;
        exp_w   = reset && !flush && (m_pend || (acc && psh));
        exp_r   = acc && pp;
        chk("in_ready", in_ready, exp_rdy);
        chk("ras_w_en", ras_w_en, exp_w);
        chk("ras_r_en", ras_r_en, exp_r);
        if (exp_w) chk("ras_waddr", ras_waddr, m_pend ? m_pend_addr : in_pc + 32'd4);
        chk("ras_occ", ras_occ, q.size());
        chk("out_valid", out_valid, m_ov);
        chk("out_pc", out_pc, m_pc);
        chk("out_kind", out_kind, m_kind);
        chk("out_taken", out_taken, m_taken);
        chk("out_target", out_target, m_target);
        if (!reset) begin
            q.delete();
            m_pend = 0; m_ov = 0; m_pc = 0; m_kind = 0; m_taken = 0; m_target = 0;
        end else if (flush) begin
            m_pend = 0; m_ov = 0;
        end else begin
            if (m_pend) begin
                q_push(m_pend_addr);
                m_pend = 0;
            end
            if (acc) begin
                if (pp) void'(q.pop_back());
                if (psh) q_push(in_pc + 32'd4);
                if (coro) begin
                    m_pend = 1;
                    m_pend_addr = in_pc + 32'd4;
                end
                m_ov = 1; m_pc = in_pc; m_kind = k; m_taken = tk; m_target = tg;
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] ins, output logic w, output logic r);
        w = 1'b0; r = 1'b0;
        in_pc = pc; in_instr = ins; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_ready) begin
                w = ras_w_en; r = ras_r_en;
                @(posedge clock); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        checks++; errors++;
        $display("FAIL send_timeout actual=no_accept expected=accept pc=%h", pc);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] k, input logic tk,
                              input logic [31:0] tg, input int occ);
        @(negedge clock);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_kind"}, out_kind, k);
        chk({tag, "_taken"}, out_taken, tk);
        chk({tag, "_target"}, out_target, tg);
        chk({tag, "_occ"}, ras_occ, occ);
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b1;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0, 1:       w = {w[31:12], pick_reg(), 7'b1101111};
            2, 3, 4, 5: w = {w[31:20], pick_reg(),
                             ($urandom_range(0, 7) == 0) ? w[14:12] : 3'b000,
                             pick_reg(), 7'b1100111};
            default:    w = w;
        endcase
        return w;
    endfunction

    initial begin
        logic w, r;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = 32'd0; in_instr = 32'd0; out_ready = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        @(negedge clock);
        chk("rst_valid", out_valid, 0);
        chk("rst_kind", out_kind, 0);
        chk("rst_target", out_target, 0);
        chk("rst_occ", ras_occ, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_wen", ras_w_en, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Call/return pair.
        send(32'h100, enc_jal(5'd1, 21'h20), w, r);
        chk("call_wen", w, 1);
        expect_out("call", 2'd2, 1'b1, 32'h120, 1);
        send(32'h120, enc_jalr(5'd0, 5'd1), w, r);
        chk("ret_ren", r, 1);
        expect_out("ret", 2'd3, 1'b1, 32'h104, 0);

        // Return on an empty stack.
        do_reset();
        send(32'h180, enc_jalr(5'd0, 5'd5), w, r);
        chk("empty_ren", r, 0);
        expect_out("empty", 2'd3, 1'b0, 32'h0, 0);

        // Overflow: occupancy saturates, the ninth return goes untaken.
        do_reset();
        for (int i = 0; i < 10; i++) send(32'h1000 + 32'(i * 16), enc_jal(5'd1, 21'h10), w, r);
        @(negedge clock);
        chk("ovf_occ", ras_occ, 8);
        @(posedge clock); #1;
        for (int i = 9; i >= 2; i--) begin
            send(32'h2000, enc_jalr(5'd0, 5'd1), w, r);
            expect_out("ovf_ret", 2'd3, 1'b1, 32'h1000 + 32'(i * 16) + 32'd4, i - 2);
        end
        send(32'h2000, enc_jalr(5'd0, 5'd1), w, r);
        expect_out("ovf_ninth", 2'd3, 1'b0, 32'h0, 0);

        // Coroutine swap after a call.
        do_reset();
        send(32'h200, enc_jal(5'd1, 21'h40), w, r);
        expect_out("co_call", 2'd2, 1'b1, 32'h240, 1);
        send(32'h300, enc_jalr(5'd1, 5'd5), w, r);
`ifdef RAS_COROUTINE_EN
        chk("co_ren", r, 1);
        chk("co_wen_n", w, 0);
        @(negedge clock);
        chk("co_wen_n1", ras_w_en, 1);
        chk("co_waddr", ras_waddr, 32'h304);
        chk("co_ready", in_ready, 0);
        chk("co_kind", out_kind, 2'd3);
        chk("co_target", out_target, 32'h204);
        chk("co_taken", out_taken, 1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("co_occ", ras_occ, 1);
        @(posedge clock); #1;
`else
        chk("co_wen", w, 1);
        chk("co_ren", r, 0);
        expect_out("co", 2'd2, 1'b0, 32'h0, 2);
`endif

        // Backpressure holds the output and blocks fetch.
        out_ready = 1'b0;
        send(32'h400, enc_jal(5'd0, 21'h8), w, r);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_pc", out_pc, 32'h400);
            chk("bp_kind", out_kind, 2'd1);
            chk("bp_target", out_target, 32'h408);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;

        // Flush in the cycle after a coroutine accept.
        send(32'h500, enc_jalr(5'd1, 5'd5), w, r);
        flush = 1'b1;
        @(negedge clock);
        chk("fl_wen", ras_w_en, 0);
        chk("fl_ready", in_ready, 0);
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        chk("fl_valid", out_valid, 0);
        chk("fl_idle", in_ready, 1);
        @(posedge clock); #1;

        // Reset in the cycle after a coroutine accept.
        send(32'h600, enc_jalr(5'd1, 5'd5), w, r);
        reset = 1'b0;
        @(negedge clock);
        chk("mr_wen", ras_w_en, 0);
        chk("mr_ready", in_ready, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("mr_valid", out_valid, 0);
        chk("mr_kind", out_kind, 0);
        chk("mr_pc", out_pc, 0);
        chk("mr_occ", ras_occ, 0);
        chk("mr_ready", in_ready, 1);
        @(posedge clock); #1;

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            reset     = ($urandom_range(0, 400) != 0);
            in_pc     = $urandom & 32'hFFFF_FFFC;
            in_instr  = rnd_instr();
            @(posedge clock); #1;
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b1; out_ready = 1'b1;
        repeat (4) begin @(posedge clock); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Fetch-side controller that drives the return address stack's push/pop interface and turns its top-of-stack output into a registered next-PC prediction. It sits between instruction fetch and the RAS. It classifies each fetched RV32 JAL/JALR as jump, call, return or coroutine swap. It sequences the RAS write/read enables and keeps a saturating shadow occupancy count, so returns on an empty stack are never predicted.

## Interface
- `DEPTH`, 8: entry count of the attached RAS; sets occupancy saturation.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low reset (asserted when 0).
- `flush` in 1: backend redirect; kills the output stage and any pending sequence.
- `in_valid` in 1 / `in_ready` out 1: fetch handshake.
- `in_pc` in 32: PC of fetched instruction.
- `in_instr` in 32: fetched instruction word.
- `out_valid` out 1 / `out_ready` in 1: prediction handshake.
- `out_pc` out 32: PC of the predicted instruction.
- `out_kind` out 2: 00 none, 01 jump, 10 call, 11 return.
- `out_taken` out 1: `out_target` is valid.
- `out_target` out 32: predicted next PC.
- `ras_waddr` out 32: push data (return address).
- `ras_w_en` out 1: RAS push.
- `ras_r_en` out 1: RAS pop.
- `ras_raddr` in 32: RAS top of stack (combinational in RAS).
- `ras_occ` out $clog2(DEPTH)+1: shadow occupancy.

## Operation
- Link register: x1 or x5. JAL is opcode 1101111. JALR is opcode 1100111 with funct3 000. All other instructions give kind 00, taken 0.
- JAL, rd not link: kind 01, taken 1, target = pc + sign-extended J-immediate.
- JAL, rd link: kind 10, push pc+4, taken 1, target as above.
- JALR, rd link, rs1 not link: kind 10, push pc+4, taken 0.
- JALR, rd link, rs1 link, rs1 == rd: same as the previous case (push only).
- JALR, rd not link, rs1 link: kind 11, pop. Taken 1 with target = `ras_raddr` if occ > 0; otherwise no pop and taken 0.
- JALR, rd link, rs1 link, rs1 != rd: coroutine, kind 11 (see Configuration).
- Accept: `in_valid & in_ready`. `in_ready` = reset deasserted & !flush & state==IDLE & (!out_valid | out_ready).
- FSM states:
  - IDLE: normal accept.
  - SWAP_PUSH: second cycle of a coroutine swap.
  - IDLE -> SWAP_PUSH on an accepted coroutine with the feature enabled.
  - SWAP_PUSH -> IDLE unconditionally after one cycle, or on flush.
- Push/pop enables are combinational and asserted only in the accept cycle, except the SWAP_PUSH push. `ras_w_en` and `ras_r_en` are never both 1 in one cycle.
- Occupancy:
  - push: occ = min(occ+1, DEPTH).
  - pop: occ-1, only when occ > 0.
  - The RAS itself wraps; the controller saturates.
- Flush clears out_valid and returns to IDLE. A pending SWAP_PUSH push is dropped. occ is not repaired.
- Reset: out_valid=0, out_kind=0, out_taken=0, out_target=0, out_pc=0, state IDLE, occ=0. ras_w_en, ras_r_en and in_ready are 0 while reset=0.

## Timing
- Prediction latency is 1 cycle: accept in cycle N, out_* valid from cycle N+1.
- Output is held stable while out_valid & !out_ready.
- A pop samples `ras_raddr` in the accept cycle, before the pointer moves.
- A push writes the RAS at the end of the accept cycle. A return accepted in the next cycle sees the pushed address.
- Coroutine: cycle N pops and captures the target; cycle N+1 (SWAP_PUSH) pushes pc+4 with in_ready=0. The next accept is possible at N+2.
- Flush has priority over accept and out_ready. out_valid is 0 from the cycle after flush.

## Configuration
- `RAS_COROUTINE_EN` defined: coroutine JALR runs the two-cycle pop-then-push via SWAP_PUSH. Kind 11, target from the pop; taken 0 if occ was 0, and in that case the pop is skipped but the push still occurs.
- `RAS_COROUTINE_EN` undefined: the SWAP_PUSH state is not built. Coroutine JALR is treated as a call: kind 10, push pc+4, taken 0, single cycle.

## Test plan
- Call/return pair:
  - JAL x1 at pc 0x100, then JALR x0,0(x1) -> push 0x104, occ 1.
  - Return predicted kind 11, taken 1, target 0x104; occ 0.
- Empty return: after reset, JALR x0,0(x5) -> no ras_r_en, kind 11, taken 0, occ stays 0.
- Overflow: DEPTH=8, 10 calls -> occ saturates at 8; 8 returns predict taken; the 9th return predicts taken 0.
- Coroutine with macro: after a call at 0x200, JALR x1,0(x5) at 0x300 -> cycle N r_en=1, target 0x204; cycle N+1 w_en=1 with waddr 0x304, in_ready=0; occ back to 1.
- Backpressure and flush: hold out_ready=0 -> output stable and in_ready=0. Assert flush with a SWAP_PUSH pending -> out_valid 0 next cycle, no push, state IDLE.
- Mid-operation reset: reset=0 during SWAP_PUSH -> no push, all outputs at reset values the next cycle.
